// File: rtl/keypad_event_encoder.sv
// Keypad event encoder: synchronises and debounces a raw key vector, encodes
// the debounced vector under the multi-key policy (one key -> that key, two
// keys -> higher index, three or more -> lowest index) and queues one event
// per press in a small FIFO with a valid/ready consumer interface.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no debounced key held; next code_valid pushes one event
// S_HELD | event already issued for this press; wait for full release
module keypad_event_encoder #(
  parameter int                 NUM_KEYS        = 12,
  parameter int                 CODE_W          = 4,
  parameter logic [CODE_W-1:0]  BLANK_CODE      = CODE_W'(14),
  parameter int                 DEBOUNCE_CYCLES = 4,
  parameter int                 FIFO_DEPTH      = 4,
  localparam int                CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  localparam int                CNTF_W          = $clog2(FIFO_DEPTH + 1),
  localparam int                PTR_W           = $clog2(FIFO_DEPTH),
  localparam int                PC_W            = $clog2(NUM_KEYS + 1)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [NUM_KEYS-1:0] key_i,
  input  logic                clear_i,
  output logic [CODE_W-1:0]   code_o,
  output logic                code_valid_o,
  output logic [CODE_W-1:0]   ev_code_o,
  output logic                ev_valid_o,
  input  logic                ev_ready_i,
  output logic                overflow_o,
  output logic [CNTF_W-1:0]   fifo_count_o
);

  typedef enum logic {S_IDLE, S_HELD} state_t;

  logic [NUM_KEYS-1:0] sync1_q, raw_s_q;
  logic [NUM_KEYS-1:0] cand_q, stable_q;
  logic [CNT_W-1:0]    cnt_q;

  state_t state_q, state_d;
  logic   push_req;

  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNTF_W-1:0] count_q;
  logic              ovf_q;

  logic [PC_W-1:0]   pcnt;
  logic [CODE_W-1:0] lo_idx, hi_idx;

  logic fifo_full, fifo_empty, do_push, do_pop, drop;

  // Two-flop synchroniser on every raw key line.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      raw_s_q <= '0;
    end else begin
      sync1_q <= key_i;
      raw_s_q <= sync1_q;
    end
  end

  // Debounce: a new candidate restarts the count; the count saturates once the
  // candidate has been seen long enough, and stable keeps reloading it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else if (raw_s_q != cand_q) begin
      cand_q <= raw_s_q;
      cnt_q  <= '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_q <= cand_q;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Popcount plus lowest and highest set index of the debounced vector.
  always_comb begin
    pcnt   = '0;
    lo_idx = '0;
    hi_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      pcnt = pcnt + PC_W'(stable_q[i]);
      if (stable_q[i]) hi_idx = CODE_W'(i);
    end
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (stable_q[i]) lo_idx = CODE_W'(i);
    end
  end

  // Multi-key policy: a single key is both lowest and highest index.
  always_comb begin
    code_valid_o = (pcnt != '0);
    if (pcnt == '0)              code_o = BLANK_CODE;
    else if (pcnt == PC_W'(2))   code_o = hi_idx;
    else                         code_o = lo_idx;
  end

  // Event FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Event FSM: one push per press; a full release re-arms it. clear does not
  // touch this FSM, so a key held across a flush stays consumed.
  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (code_valid_o) begin
          push_req = 1'b1;
          state_d  = S_HELD;
        end
      end
      S_HELD: begin
        if (!code_valid_o) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fifo_full  = (count_q == CNTF_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign do_pop     = !fifo_empty && ev_ready_i && !clear_i;
  assign do_push    = push_req && !clear_i && (!fifo_full || do_pop);
  assign drop       = push_req && !clear_i && fifo_full && !do_pop;

  // FIFO storage; a push while full is only allowed when the head leaves
  // on the same edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wptr_q] <= code_o;
    end
  end

  // FIFO pointers, occupancy and sticky overflow; clear wins over everything.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNTF_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNTF_W'(1);
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign ev_valid_o   = !fifo_empty;
  assign ev_code_o    = fifo_empty ? BLANK_CODE : mem_q[rptr_q];
  assign overflow_o   = ovf_q;
  assign fifo_count_o = count_q;

endmodule

// File: doc/keypad_event_encoder.md
Name: keypad_event_encoder

Overview:
- Parametrised, clocked successor to the combinational keypad encoder.
- Synchronises and debounces an N-key raw vector, then applies the team's multi-key policy: 1 key → that key, 2 keys → higher index, ≥3 keys → lowest index.
- Exposes a live debounced code and queues one event per press in a FIFO with valid/ready output.
- Sits between the keypad pins and the lock-controller FSM.

Parameters:
- NUM_KEYS, 12: number of key inputs. Legal range 2..16.
- CODE_W, 4: code width. Must satisfy CODE_W ≥ clog2(NUM_KEYS).
- BLANK_CODE, 4'b1110: code driven when no key is selected. Must lie outside 0..NUM_KEYS-1.
- DEBOUNCE_CYCLES, 4: consecutive stable samples required. Minimum 1.
- FIFO_DEPTH, 4: event queue depth. Power of two, minimum 2.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- key  in  NUM_KEYS  raw key levels, asynchronous, 1 = pressed.
- clear  in  1  synchronous flush of FIFO and overflow flag.
- code  out  CODE_W  live encoded key from debounced vector.
- code_valid  out  1  at least one debounced key pressed.
- ev_code  out  CODE_W  FIFO head code. BLANK_CODE when empty.
- ev_valid  out  1  FIFO non-empty.
- ev_ready  in  1  consumer accepts head when ev_valid && ev_ready.
- overflow  out  1  sticky: a press event was dropped.
- fifo_count  out  clog2(FIFO_DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst_n=0, asynchronous): every flop cleared. Outputs: code=BLANK_CODE, code_valid=0, ev_valid=0, ev_code=BLANK_CODE, overflow=0, fifo_count=0. FSM enters IDLE.
- Sync: 2-flop synchroniser per bit produces raw_s.
- Debounce: register cand plus counter cnt, of width clog2(DEBOUNCE_CYCLES+1).
  - If raw_s != cand: cand←raw_s, cnt←0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable←cand, and cnt holds.
  - Else: cnt←cnt+1.
- Encoding: combinational from stable, using popcount p.
  - p=0: code=BLANK_CODE, code_valid=0.
  - p=1: index of the set bit.
  - p=2: higher index.
  - p≥3: lowest index.
- Latency: a clean key change captured at edge 1 appears on code after edge DEBOUNCE_CYCLES+3. A glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable.
- Event FSM:
  - IDLE: when code_valid=1, push code into the FIFO and go to HELD. ev_valid rises one edge after code_valid.
  - HELD: when code_valid=0, go to IDLE. Changes of the selected key while in HELD generate no event; a release is required before the next event.
- FIFO: circular buffer with wrapping read/write pointers.
  - Pop when ev_valid && ev_ready.
  - Push when full with simultaneous pop: both happen, count unchanged, no overflow.
  - Push when full without pop: event dropped, overflow←1, held until clear or reset.
  - Pop when empty: impossible, because ev_valid=0.
- clear:
  - Same edge: FIFO emptied (pointers and count to 0), overflow←0.
  - Debounce state and FSM are unaffected, so a held key does not re-trigger.
  - A push coincident with clear is discarded.
- Reset mid-debounce or mid-hold: all state is lost. After rst_n deasserts, a key still held is treated as a fresh press once debounced.

Test Plan:
- Defaults, press key[5] steady from edge 1, ev_ready=0 → code=5 and code_valid=1 after edge 7; ev_valid=1, ev_code=5, fifo_count=1 after edge 8.
- key[2]+key[9] together → code=9. key[1]+key[4]+key[11] → code=1. No key → code=1110, code_valid=0.
- key[3] pulsed for 3 cycles with DEBOUNCE_CYCLES=4 → code_valid stays 0 and no event is queued.
- ev_ready=0; five separate press/release cycles of keys 0,1,2,3,4 → fifo_count=4, overflow=1. Then ev_ready=1 → pops 0,1,2,3 in order, then ev_valid=0 and ev_code=1110.
- FIFO full while a press lands on the same edge as a pop → fifo_count stays 4, overflow stays 0, new code at the tail. Holding key[7] and rolling to key[8] without release → no second event.
- clear while key[6] is held with 2 events queued → fifo_count=0, overflow=0 next edge, and no new event until release and re-press. Assert rst_n=0 mid-debounce → all outputs at reset values immediately.
